// File: rtl/flush_ctrl.sv
// flush_ctrl: turns flush requests into a drained, stall-safe flush window with completion reporting
module flush_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int DRAIN_CYCLES = 0,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_req,
    input  logic                 stall,
    output logic                 clk_en,
    output logic                 flush,
    output logic                 busy,
    output logic                 flush_done,
    output logic [CNT_WIDTH-1:0] flush_count
);
    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LD = CNT_WIDTH'(DRAIN_CYCLES);
    localparam logic [CNT_WIDTH-1:0] FLUSH_LD = CNT_WIDTH'(FLUSH_CYCLES);
    localparam bit                   HAS_DRAIN = DRAIN_CYCLES > 0;

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] rem, rem_nx;
    logic                 pending, pending_nx;

    // state, counters, registered clock enable and completion count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem         <= '0;
            pending     <= 1'b0;
            clk_en      <= 1'b0;
            flush_count <= '0;
        end else begin
            state       <= state_nx;
            rem         <= rem_nx;
            pending     <= pending_nx;
            clk_en      <= ~stall;
            flush_count <= flush_count + (state == DONE ? ONE : '0);
        end
    end

    // next state; DRAIN and FLUSH only advance on cycles the consumers actually clock
    always_comb begin
        state_nx   = state;
        rem_nx     = rem;
        pending_nx = pending | (flush_req & (state != IDLE));
        case (state)
            IDLE: if (flush_req | pending) begin
                pending_nx = 1'b0;
                state_nx   = HAS_DRAIN ? DRAIN : FLUSH;
                rem_nx     = HAS_DRAIN ? DRAIN_LD : FLUSH_LD;
            end
            DRAIN: if (clk_en) begin
                rem_nx   = rem == ONE ? FLUSH_LD : rem - ONE;
                state_nx = rem == ONE ? FLUSH : DRAIN;
            end
            FLUSH: if (clk_en) begin
                rem_nx   = rem - ONE;
                state_nx = rem == ONE ? DONE : FLUSH;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign flush      = state == FLUSH;
    assign busy       = state != IDLE;
    assign flush_done = state == DONE;
endmodule

// File: tb/tb_flush_ctrl.sv
// tb_flush_ctrl: directed checks of flush_ctrl across four parameterisations
module tb_flush_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, stl, ce, fl, bz, dn;
    logic [7:0] c1, c2, c3;
    logic [1:0] c4;
    logic       cons;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    flush_ctrl #(.FLUSH_CYCLES(1), .DRAIN_CYCLES(0), .CNT_WIDTH(8)) u1 (
        .clk(clk), .rst_n(rst_n), .flush_req(req[0]), .stall(stl[0]), .clk_en(ce[0]),
        .flush(fl[0]), .busy(bz[0]), .flush_done(dn[0]), .flush_count(c1));
    flush_ctrl #(.FLUSH_CYCLES(2), .DRAIN_CYCLES(0), .CNT_WIDTH(8)) u2 (
        .clk(clk), .rst_n(rst_n), .flush_req(req[1]), .stall(stl[1]), .clk_en(ce[1]),
        .flush(fl[1]), .busy(bz[1]), .flush_done(dn[1]), .flush_count(c2));
    flush_ctrl #(.FLUSH_CYCLES(1), .DRAIN_CYCLES(3), .CNT_WIDTH(8)) u3 (
        .clk(clk), .rst_n(rst_n), .flush_req(req[2]), .stall(stl[2]), .clk_en(ce[2]),
        .flush(fl[2]), .busy(bz[2]), .flush_done(dn[2]), .flush_count(c3));
    flush_ctrl #(.FLUSH_CYCLES(1), .DRAIN_CYCLES(0), .CNT_WIDTH(2)) u4 (
        .clk(clk), .rst_n(rst_n), .flush_req(req[3]), .stall(stl[3]), .clk_en(ce[3]),
        .flush(fl[3]), .busy(bz[3]), .flush_done(dn[3]), .flush_count(c4));

    // consumer register whose flush value is 1 and which otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cons <= 1'b0;
        else if (ce[0] && fl[0]) cons <= 1'b1;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if ({ce, fl, bz, dn} !== 16'h0) begin n_bad++; $display("FAIL reset_outs got %h want 0000", {ce, fl, bz, dn}); end
        n_cmp++; if ({c1, c2, c3, c4} !== 26'h0) begin n_bad++; $display("FAIL reset_counts got %h want 0", {c1, c2, c3, c4}); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (ce !== 4'hf) begin n_bad++; $display("FAIL release_clk_en got %h want f", ce); end
        n_cmp++; if ({fl, bz} !== 8'h0) begin n_bad++; $display("FAIL release_idle got %h want 00", {fl, bz}); end
    endtask

    task automatic test_basic;
        req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        n_cmp++; if ({fl[0], bz[0], dn[0], cons} !== 4'b1100) begin n_bad++; $display("FAIL basic_t1 got %b want 1100", {fl[0], bz[0], dn[0], cons}); end
        step();
        n_cmp++; if ({fl[0], bz[0], dn[0], cons} !== 4'b0111) begin n_bad++; $display("FAIL basic_t2 got %b want 0111", {fl[0], bz[0], dn[0], cons}); end
        n_cmp++; if (c1 !== 8'd0) begin n_bad++; $display("FAIL basic_cnt_t2 got %0d want 0", c1); end
        step();
        n_cmp++; if ({fl[0], bz[0], dn[0], cons} !== 4'b0001) begin n_bad++; $display("FAIL basic_t3 got %b want 0001", {fl[0], bz[0], dn[0], cons}); end
        n_cmp++; if (c1 !== 8'd1) begin n_bad++; $display("FAIL basic_cnt got %0d want 1", c1); end
    endtask

    task automatic test_stall;
        int nfl = 0;
        int neff = 0;
        int ndn = 0;
        req[1] = 1'b1;
        stl[1] = 1'b1;
        step();
        req[1] = 1'b0;
        n_cmp++; if ({ce[1], fl[1]} !== 2'b01) begin n_bad++; $display("FAIL stall_t1 got %b want 01", {ce[1], fl[1]}); end
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) stl[1] = 1'b0;
            nfl += int'(fl[1]);
            neff += int'(fl[1] & ce[1]);
            ndn += int'(dn[1]);
            step();
        end
        n_cmp++; if (nfl !== 5) begin n_bad++; $display("FAIL stall_flush_cycles got %0d want 5", nfl); end
        n_cmp++; if (neff !== 2) begin n_bad++; $display("FAIL stall_effective got %0d want 2", neff); end
        n_cmp++; if (ndn !== 1) begin n_bad++; $display("FAIL stall_done got %0d want 1", ndn); end
        n_cmp++; if (c2 !== 8'd1) begin n_bad++; $display("FAIL stall_cnt got %0d want 1", c2); end
    endtask

    task automatic test_drain;
        req[2] = 1'b1;
        step();
        req[2] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if ({fl[2], dn[2], bz[2]} !== {k == 4, k == 5, 1'b1}) begin
                n_bad++;
                $display("FAIL drain_t%0d got %b want %b", k, {fl[2], dn[2], bz[2]}, {k == 4, k == 5, 1'b1});
            end
            step();
        end
        n_cmp++; if ({bz[2], c3} !== {1'b0, 8'd1}) begin n_bad++; $display("FAIL drain_end got %h want 001", {bz[2], c3}); end
    endtask

    task automatic test_merge;
        logic [7:0] base = c2;
        logic       prev = 1'b0;
        int         nl = 0;
        int         ndn = 0;
        int         neff = 0;
        for (int k = 0; k <= 14; k++) begin
            req[1] = k <= 3;
            stl[1] = k == 1;
            nl += int'(fl[1] & ~prev);
            ndn += int'(dn[1]);
            neff += int'(fl[1] & ce[1]);
            prev = fl[1];
            step();
        end
        req[1] = 1'b0;
        n_cmp++; if (nl !== 2) begin n_bad++; $display("FAIL merge_launches got %0d want 2", nl); end
        n_cmp++; if (ndn !== 2) begin n_bad++; $display("FAIL merge_done got %0d want 2", ndn); end
        n_cmp++; if (neff !== 4) begin n_bad++; $display("FAIL merge_effective got %0d want 4", neff); end
        n_cmp++; if (c2 - base !== 8'd2) begin n_bad++; $display("FAIL merge_cnt_delta got %0d want 2", c2 - base); end
        n_cmp++; if (bz[1] !== 1'b0) begin n_bad++; $display("FAIL merge_idle got %b want 0", bz[1]); end
    endtask

    task automatic test_reset_mid;
        req[1] = 1'b1;
        step();
        step();
        req[1] = 1'b0;
        n_cmp++; if (fl[1] !== 1'b1) begin n_bad++; $display("FAIL mid_in_flush got %b want 1", fl[1]); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({fl[1], bz[1]} !== 2'b00) begin n_bad++; $display("FAIL mid_async got %b want 00", {fl[1], bz[1]}); end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++; if ({fl[1], bz[1]} !== 2'b00) begin n_bad++; $display("FAIL mid_no_pending_%0d got %b want 00", k, {fl[1], bz[1]}); end
        end
        n_cmp++; if (c2 !== 8'd0) begin n_bad++; $display("FAIL mid_cnt got %0d want 0", c2); end
    endtask

    task automatic test_wrap;
        for (int n = 1; n <= 5; n++) begin
            req[3] = 1'b1;
            step();
            req[3] = 1'b0;
            step();
            step();
            step();
            if (n == 4) begin
                n_cmp++; if (c4 !== 2'd0) begin n_bad++; $display("FAIL wrap_4 got %0d want 0", c4); end
            end
        end
        n_cmp++; if (c4 !== 2'd1) begin n_bad++; $display("FAIL wrap_5 got %0d want 1", c4); end
    endtask

    initial begin
        req = '0;
        stl = '0;
        test_reset();
        test_basic();
        test_stall();
        test_drain();
        test_merge();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
